// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared types, defaults and helpers for the UART transmit FIFO
package uart_tx_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

    localparam int DEFAULT_DEPTH = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - producer and uart8n1 handshake bundle (optional dropCnt: UART_TX_FIFO_STATS_EN)
interface uart_tx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic            wrEn;
    logic [7:0]      wrData;
    logic            flush;
    logic            full;
    logic            empty;
    logic [ADDR_W:0] level;
    logic            ovf;
    logic            txStart;
    logic [7:0]      txData;
    logic            txBusy;
    logic            txDone;
`ifdef UART_TX_FIFO_STATS_EN
    logic [15:0]     dropCnt;

    modport master (
        output wrEn, wrData, flush, txBusy, txDone,
        input  full, empty, level, ovf, txStart, txData, dropCnt
    );

    modport slave (
        input  wrEn, wrData, flush, txBusy, txDone,
        output full, empty, level, ovf, txStart, txData, dropCnt
    );
`else
    modport master (
        output wrEn, wrData, flush, txBusy, txDone,
        input  full, empty, level, ovf, txStart, txData
    );

    modport slave (
        input  wrEn, wrData, flush, txBusy, txDone,
        output full, empty, level, ovf, txStart, txData
    );
`endif
endinterface

// File: rtl/uart_tx_fifo_mem.sv
// rtl/uart_tx_fifo_mem.sv - DEPTH x 8 register array, one write port, one async read port
module uart_tx_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];

    // Storage has no reset; occupancy tracking in the parent decides what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and start sequencer for uart8n1 (optional dropCnt: UART_TX_FIFO_STATS_EN)
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstN,
    uart_tx_fifo_if.slave bus
);

    localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

    tx_state_t         state;
    tx_state_t         state_next;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level_q;
    logic [7:0]        tx_data_q;
    logic [7:0]        rd_data;
    logic              ovf_q;
    logic              tx_start;
    logic              full_w;
    logic              empty_w;
    logic              push;
    logic              pop;

    assign full_w  = (level_q == LEVEL_FULL);
    assign empty_w = (level_q == '0);

    // flush wins over both sides: the same-edge write is discarded and no byte
    // is pulled out of a queue that is being cleared.
    assign push = bus.wrEn && !full_w && !bus.flush;
    assign pop  = (state == IDLE) && !empty_w && !bus.txBusy && !bus.flush;

    uart_tx_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.wrData),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Pointers and exact occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (bus.flush) begin
            rd_ptr  <= wr_ptr;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + (ADDR_W + 1)'(1);
                2'b01:   level_q <= level_q - (ADDR_W + 1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Byte handed to the UART is captured on pop and held until the next pop.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            tx_data_q <= 8'h00;
        end else if (pop) begin
            tx_data_q <= rd_data;
        end
    end

    // Overflow pulse uses the pre-edge full flag, so a same-edge pop does not rescue the write.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= bus.wrEn && full_w;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sequencer transitions; txDone in WAIT_BUSY covers a UART that finishes before busy is seen.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_next = START;
                end
            end
            START: begin
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.txDone) begin
                    state_next = IDLE;
                end else if (bus.txBusy) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.txDone) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Start pulse is decoded from the registered state, giving exactly one cycle high.
    always_comb begin
        tx_start = 1'b0;
        if (state == START) begin
            tx_start = 1'b1;
        end
    end

`ifdef UART_TX_FIFO_STATS_EN
    logic [15:0] drop_cnt;

    // Saturating count of dropped writes, cleared by flush.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            drop_cnt <= 16'h0000;
        end else if (bus.flush) begin
            drop_cnt <= 16'h0000;
        end else if (ovf_q && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign bus.dropCnt = drop_cnt;
`endif

    assign bus.full    = full_w;
    assign bus.empty   = empty_w;
    assign bus.level   = level_q;
    assign bus.ovf     = ovf_q;
    assign bus.txStart = tx_start;
    assign bus.txData  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo with a behavioural UART sink
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    logic rstN;

    uart_tx_fifo_if #(.ADDR_W(4)) bus ();

    uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         done_cyc = 0;
    int         last_gap = 0;
    int         frames = 0;
    int         busy_len = 6;
    logic       sink_busy;
    logic       sink_done;
    logic       block_busy;
    logic       sending;
    logic [7:0] sb[$];

    assign bus.txBusy = sink_busy | block_busy;
    assign bus.txDone = sink_done;

    always @(posedge clk) cyc <= cyc + 1;

    // UART sink: pops the scoreboard on each txStart and checks pulse width and data hold.
    initial begin : sink
        logic [7:0] held;
        logic       aborted;
        sink_busy = 1'b0;
        sink_done = 1'b0;
        sending   = 1'b0;
        forever begin
            @(negedge clk);
            if (rstN && bus.txStart) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL sink_unexpected_start: txData=%h with no byte pending", bus.txData);
                    held = bus.txData;
                end else begin
                    held = sb.pop_front();
                    if (bus.txData !== held) begin
                        fails++;
                        $display("FAIL sink_data: got %h expected %h", bus.txData, held);
                    end
                end
                last_gap = cyc - done_cyc;
                sending  = 1'b1;
                aborted  = 1'b0;
                @(negedge clk);
                if (!rstN) begin
                    aborted = 1'b1;
                end else begin
                    tests++;
                    if (bus.txStart !== 1'b0) begin
                        fails++;
                        $display("FAIL sink_start_width: txStart=%b expected 0", bus.txStart);
                    end
                end
                for (int i = 0; i < busy_len && !aborted; i++) begin
                    sink_busy = 1'b1;
                    @(negedge clk);
                    if (!rstN) begin
                        aborted = 1'b1;
                    end else begin
                        tests++;
                        if (bus.txData !== held) begin
                            fails++;
                            $display("FAIL sink_data_hold: got %h expected %h", bus.txData, held);
                        end
                    end
                end
                if (!aborted) begin
                    sink_busy = 1'b0;
                    sink_done = 1'b1;
                    done_cyc  = cyc;
                    @(negedge clk);
                    sink_done = 1'b0;
                    frames++;
                end
                sink_busy = 1'b0;
                sending   = 1'b0;
            end
        end
    end

    task automatic write_byte(input logic [7:0] d, input bit accepted);
        bus.wrEn   = 1'b1;
        bus.wrData = d;
        if (accepted) sb.push_back(d);
        @(negedge clk);
        bus.wrEn = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (sb.size() == 0 && !sending && bus.empty === 1'b1) break;
            @(negedge clk);
        end
        tests++;
        if (!(sb.size() == 0 && !sending && bus.empty === 1'b1)) begin
            fails++;
            $display("FAIL %s_drain: %0d bytes pending after %0d cycles, expected 0", name, sb.size(), budget);
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        tests += 6;
        if (bus.level !== 5'd0)   begin fails++; $display("FAIL reset_level: got %0d expected 0", bus.level); end
        if (bus.empty !== 1'b1)   begin fails++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
        if (bus.full !== 1'b0)    begin fails++; $display("FAIL reset_full: got %b expected 0", bus.full); end
        if (bus.txStart !== 1'b0) begin fails++; $display("FAIL reset_txstart: got %b expected 0", bus.txStart); end
        if (bus.txData !== 8'h00) begin fails++; $display("FAIL reset_txdata: got %h expected 00", bus.txData); end
        if (bus.ovf !== 1'b0)     begin fails++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
`ifdef UART_TX_FIFO_STATS_EN
        tests++;
        if (bus.dropCnt !== 16'd0) begin fails++; $display("FAIL reset_dropcnt: got %0d expected 0", bus.dropCnt); end
`endif
        rstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int f0;
        f0 = frames;
        busy_len = 6;
        write_byte(8'hA5, 1'b1);
        tests += 2;
        if (bus.txStart !== 1'b0) begin fails++; $display("FAIL single_no_bypass: txStart=%b expected 0", bus.txStart); end
        if (bus.level !== 5'd1)   begin fails++; $display("FAIL single_level: got %0d expected 1", bus.level); end
        @(negedge clk);
        tests += 3;
        if (bus.txStart !== 1'b1) begin fails++; $display("FAIL single_start: txStart=%b expected 1", bus.txStart); end
        if (bus.txData !== 8'hA5) begin fails++; $display("FAIL single_txdata: got %h expected a5", bus.txData); end
        if (bus.level !== 5'd0)   begin fails++; $display("FAIL single_pop_level: got %0d expected 0", bus.level); end
        wait_drain("single", 200);
        tests++;
        if (frames - f0 !== 1) begin fails++; $display("FAIL single_frames: got %0d expected 1", frames - f0); end
    endtask

    task automatic test_burst_overflow();
        int f0;
        f0 = frames;
        busy_len   = 6;
        block_busy = 1'b1;
        for (int i = 0; i < 16; i++) write_byte(8'(i), 1'b1);
        tests += 2;
        if (bus.full !== 1'b1)   begin fails++; $display("FAIL burst_full: got %b expected 1", bus.full); end
        if (bus.level !== 5'd16) begin fails++; $display("FAIL burst_level: got %0d expected 16", bus.level); end
        for (int k = 0; k < 3; k++) begin
            write_byte(8'hF0 + 8'(k), 1'b0);
            tests += 2;
            if (bus.ovf !== 1'b1)    begin fails++; $display("FAIL ovf_pulse%0d: got %b expected 1", k, bus.ovf); end
            if (bus.level !== 5'd16) begin fails++; $display("FAIL ovf_level%0d: got %0d expected 16", k, bus.level); end
        end
        @(negedge clk);
        tests++;
        if (bus.ovf !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b expected 0", bus.ovf); end
`ifdef UART_TX_FIFO_STATS_EN
        tests++;
        if (bus.dropCnt !== 16'd3) begin fails++; $display("FAIL dropcnt_three: got %0d expected 3", bus.dropCnt); end
`endif
        block_busy = 1'b0;
        write_byte(8'hEE, 1'b0);
        tests += 3;
        if (bus.ovf !== 1'b1)     begin fails++; $display("FAIL ovf_with_pop: got %b expected 1", bus.ovf); end
        if (bus.level !== 5'd15)  begin fails++; $display("FAIL pop_while_full_level: got %0d expected 15", bus.level); end
        if (bus.txStart !== 1'b1) begin fails++; $display("FAIL pop_while_full_start: got %b expected 1", bus.txStart); end
        wait_drain("burst", 1000);
        tests += 2;
        if (frames - f0 !== 16)  begin fails++; $display("FAIL burst_frames: got %0d expected 16", frames - f0); end
        if (bus.empty !== 1'b1)  begin fails++; $display("FAIL burst_empty: got %b expected 1", bus.empty); end
    endtask

    task automatic test_write_while_pop();
        block_busy = 1'b1;
        for (int i = 0; i < 5; i++) write_byte(8'h50 + 8'(i), 1'b1);
        tests++;
        if (bus.level !== 5'd5) begin fails++; $display("FAIL wwp_prefill: got %0d expected 5", bus.level); end
        block_busy = 1'b0;
        write_byte(8'h55, 1'b1);
        tests += 2;
        if (bus.level !== 5'd5)   begin fails++; $display("FAIL wwp_level: got %0d expected 5", bus.level); end
        if (bus.txStart !== 1'b1) begin fails++; $display("FAIL wwp_start: got %b expected 1", bus.txStart); end
        wait_drain("wwp", 500);
    endtask

    task automatic test_back_to_back();
        busy_len   = 0;
        block_busy = 1'b1;
        write_byte(8'h90, 1'b1);
        write_byte(8'h91, 1'b1);
        block_busy = 1'b0;
        wait_drain("b2b", 200);
        tests++;
        if (last_gap !== 2) begin fails++; $display("FAIL b2b_gap: got %0d cycles expected 2", last_gap); end
        busy_len = 6;
    endtask

    task automatic test_flush();
        int f0;
        busy_len   = 30;
        block_busy = 1'b1;
        for (int i = 0; i < 11; i++) write_byte(8'h60 + 8'(i), 1'b1);
        block_busy = 1'b0;
        f0 = frames;
        @(negedge clk);
        tests++;
        if (bus.level !== 5'd10) begin fails++; $display("FAIL flush_prelevel: got %0d expected 10", bus.level); end
        repeat (3) @(negedge clk);
        bus.flush  = 1'b1;
        bus.wrEn   = 1'b1;
        bus.wrData = 8'h77;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.wrEn  = 1'b0;
        sb.delete();
        tests += 3;
        if (bus.level !== 5'd0)   begin fails++; $display("FAIL flush_level: got %0d expected 0", bus.level); end
        if (bus.empty !== 1'b1)   begin fails++; $display("FAIL flush_empty: got %b expected 1", bus.empty); end
        if (bus.txData !== 8'h60) begin fails++; $display("FAIL flush_inflight: got %h expected 60", bus.txData); end
`ifdef UART_TX_FIFO_STATS_EN
        tests++;
        if (bus.dropCnt !== 16'd0) begin fails++; $display("FAIL flush_dropcnt: got %0d expected 0", bus.dropCnt); end
`endif
        wait_drain("flush", 200);
        repeat (60) @(negedge clk);
        tests++;
        if (frames - f0 !== 1) begin fails++; $display("FAIL flush_frames: got %0d expected 1", frames - f0); end
        busy_len = 6;
    endtask

    task automatic test_reset_mid_frame();
        int f0;
        busy_len   = 30;
        block_busy = 1'b1;
        for (int i = 0; i < 3; i++) write_byte(8'h80 + 8'(i), 1'b1);
        block_busy = 1'b0;
        repeat (4) @(negedge clk);
        rstN = 1'b0;
        sb.delete();
        #1;
        tests += 4;
        if (bus.txStart !== 1'b0) begin fails++; $display("FAIL rst_mid_start: got %b expected 0", bus.txStart); end
        if (bus.level !== 5'd0)   begin fails++; $display("FAIL rst_mid_level: got %0d expected 0", bus.level); end
        if (bus.empty !== 1'b1)   begin fails++; $display("FAIL rst_mid_empty: got %b expected 1", bus.empty); end
        if (bus.txData !== 8'h00) begin fails++; $display("FAIL rst_mid_txdata: got %h expected 00", bus.txData); end
        repeat (3) @(negedge clk);
        rstN     = 1'b1;
        busy_len = 4;
        @(negedge clk);
        f0 = frames;
        write_byte(8'h3C, 1'b1);
        wait_drain("rst_mid", 200);
        tests++;
        if (frames - f0 !== 1) begin fails++; $display("FAIL rst_mid_frames: got %0d expected 1", frames - f0); end
    endtask

    initial begin
        bus.wrEn   = 1'b0;
        bus.wrData = 8'h00;
        bus.flush  = 1'b0;
        block_busy = 1'b0;
        test_reset();
        test_single();
        test_burst_overflow();
        test_write_while_pop();
        test_back_to_back();
        test_flush();
        test_reset_mid_frame();
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
